// File: rtl/ika87ad_pkg.sv
// Shared IKA87AD definitions: bus-cycle codes carried in micro-op words,
// the 2-/4-step group boundary and the microcode sequencer state encoding.
package ika87ad_pkg;

  localparam int MC_W = 18;
  localparam int AW   = 8;

  // Bus-cycle field of a micro-op word
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RD3  = 2'b01;
  localparam logic [1:0] WR3  = 2'b10;
  localparam logic [1:0] RD4  = 2'b11;
  localparam int BUS_LSB = 0;
  localparam int BUS_MSB = 1;

  localparam logic [AW-1:0] LONG_BASE = 8'd32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_ISSUE = 2'd2
  } mcseq_state_e;

endpackage

// File: rtl/ika87ad_mcseq_if.sv
// Decoder, microcode ROM and datapath signals of the microcode sequencer.
// Handshakes: the decoder start address is taken on a cycle with
// i_DEC_VALID && o_DEC_READY; a micro-op retires on a cycle with
// o_UOP_VALID && i_UOP_ACCEPT, and o_UOP stays stable until then.
interface ika87ad_mcseq_if #(
  parameter int MC_W = 18,
  parameter int AW   = 8
);
  logic            i_DEC_VALID;
  logic [AW-1:0]   i_DEC_ADDR;
  logic            o_DEC_READY;
  logic            o_MCROM_READ_TICK;
  logic [AW-1:0]   o_MCROM_ADDR;
  logic [MC_W-1:0] i_MCROM_DATA;
  logic            o_UOP_VALID;
  logic [MC_W-1:0] o_UOP;
  logic            i_UOP_ACCEPT;
  logic [1:0]      o_STEP;
  logic            i_ABORT;
  logic            o_INSTR_END;
  logic            o_SEQ_ERR;

  modport master (
    input  i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA, i_UOP_ACCEPT, i_ABORT,
    output o_DEC_READY, o_MCROM_READ_TICK, o_MCROM_ADDR, o_UOP_VALID,
           o_UOP, o_STEP, o_INSTR_END, o_SEQ_ERR
  );

  modport slave (
    output i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA, i_UOP_ACCEPT, i_ABORT,
    input  o_DEC_READY, o_MCROM_READ_TICK, o_MCROM_ADDR, o_UOP_VALID,
           o_UOP, o_STEP, o_INSTR_END, o_SEQ_ERR
  );
endinterface

// File: rtl/ika87ad_mcseq.sv
// Microcode sequencer: walks the registered microcode ROM from a decoded start
// address and issues one micro-op per step until RD4 or the group step limit.
module ika87ad_mcseq
  import ika87ad_pkg::*;
#(
  parameter int              MC_W      = ika87ad_pkg::MC_W,
  parameter int              AW        = ika87ad_pkg::AW,
  parameter logic [AW-1:0]   LONG_BASE = ika87ad_pkg::LONG_BASE
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  ika87ad_mcseq_if.master      bus,
  output mcseq_state_e         o_DBG_STATE
);

  mcseq_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    step_q, step_d;
  logic [2:0]    limit_q, limit_d;
  logic          end_q, end_d;
  logic          err_q, err_d;
  logic [2:0]    step_inc;

  assign step_inc = {1'b0, step_q} + 3'd1;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      step_q  <= '0;
      limit_q <= 3'd2;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      limit_q <= limit_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    step_d  = step_q;
    limit_d = limit_q;
    end_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_DEC_VALID) begin
          addr_d  = bus.i_DEC_ADDR;
          step_d  = '0;
          limit_d = (bus.i_DEC_ADDR < LONG_BASE) ? 3'd2 : 3'd4;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = bus.i_ABORT ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        // Abort outranks a same-cycle accept and retires nothing.
        if (bus.i_ABORT) begin
          state_d = S_IDLE;
        end else if (bus.i_UOP_ACCEPT) begin
          if (bus.i_MCROM_DATA[BUS_MSB:BUS_LSB] == RD4) begin
            end_d   = 1'b1;
            state_d = S_IDLE;
          end else if (step_inc == limit_q) begin
            end_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            step_d  = step_q + 2'd1;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The ROM word only changes on a tick, so it is stable throughout S_ISSUE.
  assign bus.o_DEC_READY       = (state_q == S_IDLE);
  assign bus.o_MCROM_READ_TICK = (state_q == S_READ);
  assign bus.o_MCROM_ADDR      = addr_q;
  assign bus.o_UOP_VALID       = (state_q == S_ISSUE);
  assign bus.o_UOP             = (state_q == S_ISSUE) ? bus.i_MCROM_DATA : '0;
  assign bus.o_STEP            = step_q;
  assign bus.o_INSTR_END       = end_q;
  assign bus.o_SEQ_ERR         = err_q;
  assign o_DBG_STATE           = state_q;

endmodule
